// File: rtl/msdap_pkg.sv
// Shared types and defaults for the MSDAP input deserializer and its zero-run counters.
package msdap_pkg;

    localparam int WORD_W_DEF   = 16;
    localparam int ZERO_RUN_DEF = 800;
    localparam int ZCNT_W       = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/zero_run_counter.sv
// Saturating count of consecutive all-zero words on one channel.
// The flag is registered on the same edge that loads the word.
module zero_run_counter
    import msdap_pkg::*;
#(
    parameter int ZERO_RUN = ZERO_RUN_DEF
) (
    input  logic Dclk,
    input  logic Reset_n,
    input  logic Clear,
    input  logic load,
    input  logic is_zero,
    output logic flag
);

    localparam logic [ZCNT_W-1:0] SAT = ZCNT_W'(ZERO_RUN);

    logic [ZCNT_W-1:0] cnt_reg;
    logic [ZCNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!is_zero)
            cnt_next = '0;
        else if (cnt_reg != SAT)
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_reg <= '0;
            flag    <= 1'b0;
        end else if (Clear) begin
            cnt_reg <= '0;
            flag    <= 1'b0;
        end else if (load) begin
            cnt_reg <= cnt_next;
            flag    <= (cnt_next == SAT);
        end
    end

endmodule

// File: rtl/msdap_input_deserializer.sv
// Frame-aligned serial-to-parallel front end for the MSDAP left/right streams.
// Optional misaligned-Frame detection is enabled by defining MSDAP_FRAME_CHECK_EN.
module msdap_input_deserializer
    import msdap_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int ZERO_RUN = ZERO_RUN_DEF,
    parameter int FLAG_LEN = 4
) (
    input  logic              Dclk,
    input  logic              Reset_n,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    input  logic              Clear,
    output logic [WORD_W-1:0] dataL,
    output logic [WORD_W-1:0] dataR,
    output logic              in_flag,
    output logic              flag_zeroL,
    output logic              flag_zeroR,
    output logic              frame_err
);

    localparam int BCNT_W = $clog2(WORD_W);
    localparam int HOLD_W = $clog2(FLAG_LEN + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLAG_LEN);

    state_t              state_reg;
    logic [BCNT_W-1:0]   bcnt_reg;
    logic [WORD_W-2:0]   sh_l_reg;
    logic [WORD_W-2:0]   sh_r_reg;
    logic [HOLD_W-1:0]   hold_reg;

    logic [WORD_W-1:0]   word_l;
    logic [WORD_W-1:0]   word_r;
    logic                misalign;
    logic                load;

    assign word_l = {sh_l_reg, InputL};
    assign word_r = {sh_r_reg, InputR};

`ifdef MSDAP_FRAME_CHECK_EN
    assign misalign = (state_reg == SHIFT) && Frame;
`else
    assign misalign = 1'b0;
`endif

    // A misaligned Frame on the final bit still wins: that word is dropped.
    assign load = (state_reg == SHIFT) && (bcnt_reg == LAST_BIT) && !misalign;

    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            bcnt_reg  <= '0;
            sh_l_reg  <= '0;
            sh_r_reg  <= '0;
            hold_reg  <= '0;
            dataL     <= '0;
            dataR     <= '0;
            in_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else if (Clear) begin
            state_reg <= IDLE;
            bcnt_reg  <= '0;
            hold_reg  <= '0;
            in_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= misalign;

            if (load) begin
                in_flag  <= 1'b1;
                hold_reg <= HOLD_INIT;
            end else if (hold_reg != '0) begin
                hold_reg <= hold_reg - 1'b1;
                if (hold_reg == HOLD_W'(1))
                    in_flag <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (Frame) begin
                        sh_l_reg  <= (WORD_W-1)'(InputL);
                        sh_r_reg  <= (WORD_W-1)'(InputR);
                        bcnt_reg  <= BCNT_W'(1);
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (misalign) begin
                        sh_l_reg <= (WORD_W-1)'(InputL);
                        sh_r_reg <= (WORD_W-1)'(InputR);
                        bcnt_reg <= BCNT_W'(1);
                    end else if (bcnt_reg == LAST_BIT) begin
                        dataL     <= word_l;
                        dataR     <= word_r;
                        bcnt_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        sh_l_reg <= word_l[WORD_W-2:0];
                        sh_r_reg <= word_r[WORD_W-2:0];
                        bcnt_reg <= bcnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    zero_run_counter #(.ZERO_RUN(ZERO_RUN)) u_zero_l (
        .Dclk    (Dclk),
        .Reset_n (Reset_n),
        .Clear   (Clear),
        .load    (load),
        .is_zero (word_l == '0),
        .flag    (flag_zeroL)
    );

    zero_run_counter #(.ZERO_RUN(ZERO_RUN)) u_zero_r (
        .Dclk    (Dclk),
        .Reset_n (Reset_n),
        .Clear   (Clear),
        .load    (load),
        .is_zero (word_r == '0),
        .flag    (flag_zeroR)
    );

endmodule

// File: tb/tb_msdap_input_deserializer.sv
// Randomized self-checking bench for msdap_input_deserializer against a word-level model.
module tb_msdap_input_deserializer;

`ifdef MSDAP_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        Dclk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Frame = 1'b0;
    logic        InputL = 1'b0;
    logic        InputR = 1'b0;
    logic        Clear = 1'b0;
    logic [15:0] dataL;
    logic [15:0] dataR;
    logic        in_flag;
    logic        flag_zeroL;
    logic        flag_zeroR;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    // Word-level reference: last words and unbounded runs of zero words.
    logic [15:0] m_l = 16'h0;
    logic [15:0] m_r = 16'h0;
    int          m_zl = 0;
    int          m_zr = 0;

    msdap_input_deserializer #(.WORD_W(16), .ZERO_RUN(800), .FLAG_LEN(4)) dut (
        .Dclk       (Dclk),
        .Reset_n    (Reset_n),
        .Frame      (Frame),
        .InputL     (InputL),
        .InputR     (InputR),
        .Clear      (Clear),
        .dataL      (dataL),
        .dataR      (dataR),
        .in_flag    (in_flag),
        .flag_zeroL (flag_zeroL),
        .flag_zeroR (flag_zeroR),
        .frame_err  (frame_err)
    );

    always #5 Dclk = ~Dclk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_load(input logic [15:0] l, input logic [15:0] r);
        m_l  = l;
        m_r  = r;
        m_zl = (l == 16'h0) ? m_zl + 1 : 0;
        m_zr = (r == 16'h0) ? m_zr + 1 : 0;
    endfunction

    task automatic step();
        @(posedge Dclk);
        #1;
    endtask

    task automatic drive_bit(input logic f, input logic l, input logic r);
        Frame  = f;
        InputL = l;
        InputR = r;
        step();
    endtask

    task automatic drive_word(input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < 16; i++)
            drive_bit(i == 0, l[15-i], r[15-i]);
        Frame = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive_bit(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({dataL, dataR} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 0000/0000", dataL, dataR);
        end
        checks++;
        if ({in_flag, flag_zeroL, flag_zeroR, frame_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {in_flag, flag_zeroL, flag_zeroR, frame_err});
        end
        Reset_n = 1'b1;
        idle(2);
        $display("reset: data=%h/%h flags=%b", dataL, dataR, {in_flag, flag_zeroL, flag_zeroR, frame_err});
    endtask

    task automatic test_basic();
        int hi;
        drive_word(16'hA5C3, 16'h0001);
        model_load(16'hA5C3, 16'h0001);
        checks++;
        if (dataL !== 16'hA5C3 || dataR !== 16'h0001) begin
            errors++;
            $display("FAIL basic_data: got %h/%h want a5c3/0001", dataL, dataR);
        end
        checks++;
        if ({flag_zeroL, flag_zeroR, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b want 000", {flag_zeroL, flag_zeroR, frame_err});
        end
        hi = in_flag ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            idle(1);
            if (in_flag) hi++;
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL basic_in_flag_len: got %0d cycles want 4", hi);
        end
        $display("basic: L=%h R=%h in_flag_cycles=%0d", dataL, dataR, hi);
    endtask

    task automatic test_back_to_back();
        logic [15:0] l, r;
        for (int n = 0; n < 24; n++) begin
            l = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            r = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            drive_word(l, r);
            model_load(l, r);
            checks++;
            if (dataL !== m_l || dataR !== m_r) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", n, dataL, dataR, m_l, m_r);
            end
            checks++;
            if ({in_flag, flag_zeroL, flag_zeroR, frame_err} !== {1'b1, m_zl >= 800, m_zr >= 800, 1'b0}) begin
                errors++;
                $display("FAIL b2b_flags[%0d]: got %b want %b", n,
                         {in_flag, flag_zeroL, flag_zeroR, frame_err}, {1'b1, m_zl >= 800, m_zr >= 800, 1'b0});
            end
            $display("b2b[%0d]: L=%h R=%h in_flag=%b", n, dataL, dataR, in_flag);
        end
    endtask

    // Runs n frames and checks the zero flags after each load against the model.
    task automatic zero_run(input string name, input int n, input logic [15:0] l, input logic [15:0] r);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            drive_word(l, r);
            model_load(l, r);
            checks++;
            if (flag_zeroL !== (m_zl >= 800) || flag_zeroR !== (m_zr >= 800) || dataL !== m_l) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL %s[%0d]: got zL=%b zR=%b L=%h want zL=%b zR=%b L=%h", name, i,
                             flag_zeroL, flag_zeroR, dataL, m_zl >= 800, m_zr >= 800, m_l);
            end
        end
        $display("%s: %0d frames, zL=%b zR=%b", name, n, flag_zeroL, flag_zeroR);
    endtask

    task automatic test_zero_run();
        drive_word(16'h0001, 16'h1234);
        model_load(16'h0001, 16'h1234);
        zero_run("zero_run_799", 799, 16'h0000, 16'h1234);
        checks++;
        if (flag_zeroL !== 1'b0) begin
            errors++;
            $display("FAIL zero_before_800: got %b want 0", flag_zeroL);
        end
        zero_run("zero_run_800th", 1, 16'h0000, 16'h1234);
        checks++;
        if (flag_zeroL !== 1'b1 || flag_zeroR !== 1'b0) begin
            errors++;
            $display("FAIL zero_at_800: got zL=%b zR=%b want 1/0", flag_zeroL, flag_zeroR);
        end
        zero_run("zero_saturate", 5, 16'h0000, 16'h1234);
        zero_run("zero_break", 1, 16'h0001, 16'h1234);
        checks++;
        if (flag_zeroL !== 1'b0) begin
            errors++;
            $display("FAIL zero_break: got %b want 0", flag_zeroL);
        end
        zero_run("zero_rerun", 800, 16'h0000, 16'h1234);
        checks++;
        if (flag_zeroL !== 1'b1) begin
            errors++;
            $display("FAIL zero_rerun_800: got %b want 1", flag_zeroL);
        end
    endtask

    task automatic test_clear();
        drive_word(16'hBEEF, 16'h1357);
        model_load(16'hBEEF, 16'h1357);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        m_zl = 0;
        m_zr = 0;
        checks++;
        if (dataL !== 16'hBEEF || dataR !== 16'h1357 || in_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_hold: got %h/%h in_flag=%b want beef/1357 in_flag=0", dataL, dataR, in_flag);
        end
        // Clear mid-word: the partial word must be discarded.
        for (int i = 0; i < 5; i++)
            drive_bit(i == 0, 1'b1, 1'b1);
        Clear = 1'b1;
        drive_bit(1'b0, 1'b1, 1'b1);
        Clear = 1'b0;
        idle(12);
        checks++;
        if (dataL !== 16'hBEEF || in_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_partial: got %h in_flag=%b want beef in_flag=0", dataL, in_flag);
        end
        zero_run("clear_pre500", 500, 16'h0000, 16'h0000);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        m_zl = 0;
        m_zr = 0;
        checks++;
        if ({in_flag, flag_zeroL, flag_zeroR} !== 3'b000 || dataL !== 16'h0000) begin
            errors++;
            $display("FAIL clear_500: got %b L=%h want 000 L=0000", {in_flag, flag_zeroL, flag_zeroR}, dataL);
        end
        zero_run("clear_post799", 799, 16'h0000, 16'h0000);
        checks++;
        if ({flag_zeroL, flag_zeroR} !== 2'b00) begin
            errors++;
            $display("FAIL clear_799: got %b want 00", {flag_zeroL, flag_zeroR});
        end
        zero_run("clear_post800th", 1, 16'h0000, 16'h0000);
        checks++;
        if ({flag_zeroL, flag_zeroR} !== 2'b11) begin
            errors++;
            $display("FAIL clear_800: got %b want 11", {flag_zeroL, flag_zeroR});
        end
    endtask

    task automatic test_misalign();
        logic [15:0] a, b, exp_w;
        int          load_p;
        logic        f, bl, br;
        a = 16'($urandom) | 16'h8000;
        b = 16'($urandom) | 16'h8000;
        load_p = FC ? 22 : 15;
        exp_w  = FC ? b : {a[15:9], b[15:7]};
        idle(6);
        for (int p = 0; p < 23; p++) begin
            f  = (p == 0) || (p == 7);
            bl = (p < 7) ? a[15-p] : b[15-(p-7)];
            br = ~bl;
            drive_bit(f, bl, br);
            if (p == load_p)
                model_load(exp_w, ~exp_w);
            checks++;
            if (frame_err !== (FC && p == 7) ||
                in_flag !== (p >= load_p && p < load_p + 4)) begin
                errors++;
                $display("FAIL misalign_p%0d: got err=%b in_flag=%b want err=%b in_flag=%b", p,
                         frame_err, in_flag, FC && p == 7, p >= load_p && p < load_p + 4);
            end
        end
        Frame = 1'b0;
        checks++;
        if (dataL !== exp_w || dataR !== ~exp_w) begin
            errors++;
            $display("FAIL misalign_data: got %h/%h want %h/%h", dataL, dataR, exp_w, ~exp_w);
        end
        $display("misalign: a=%h b=%h L=%h check_en=%0d", a, b, dataL, FC);
    endtask

    task automatic test_reset_mid();
        drive_word(16'h7E81, 16'hC001);
        model_load(16'h7E81, 16'hC001);
        for (int i = 0; i < 9; i++)
            drive_bit(i == 0, 1'b1, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({dataL, dataR} !== 32'h0 || {in_flag, flag_zeroL, flag_zeroR, frame_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid: got %h/%h %b want 0000/0000 0000", dataL, dataR,
                     {in_flag, flag_zeroL, flag_zeroR, frame_err});
        end
        m_l = 16'h0; m_r = 16'h0; m_zl = 0; m_zr = 0;
        step();
        Reset_n = 1'b1;
        idle(20);
        checks++;
        if ({dataL, dataR} !== 32'h0 || in_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got %h/%h in_flag=%b want 0000/0000 0", dataL, dataR, in_flag);
        end
        drive_word(16'h3C5A, 16'h0F0F);
        model_load(16'h3C5A, 16'h0F0F);
        checks++;
        if (dataL !== m_l || dataR !== m_r || in_flag !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: got %h/%h in_flag=%b want %h/%h 1", dataL, dataR, in_flag, m_l, m_r);
        end
        $display("reset_mid: after release L=%h R=%h", dataL, dataR);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_run();
        test_clear();
        test_misalign();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
